// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control for the ID/EX boundary.
// Decodes {funct7, funct3} and ALUOp into the 3-bit ALU control code, supports
// branch (always SUB) and pass-add (always ADD) modes, runs a MUL for MUL_LAT
// cycles while stalling upstream through busy_o, and flags undecodable
// encodings with a one-cycle illegal_o pulse.

module alu_ctrl_seq #(
    parameter int MUL_LAT = 4,   // cycles a MUL occupies EX, 1..2^CNT_W-1
    parameter int FUNCT_W = 10,  // {funct7, funct3}
    parameter int CNT_W   = 4    // MUL cycle counter width
) (
    input  logic               clk_i,
    input  logic               rst_i,      // synchronous, active-low
    input  logic               valid_i,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [1:0]         ALUOp_i,
    input  logic               flush_i,
    output logic [2:0]         ALUCtrl_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               illegal_o
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    // The counter must be able to reach MUL_LAT-1 without wrapping.
    if (MUL_LAT < 1 || MUL_LAT > (1 << CNT_W) - 1) begin : g_bad_mul_lat
        $error("alu_ctrl_seq: MUL_LAT must be in 1..2^CNT_W-1");
    end

    // The decode table is written against exactly {funct7[6:0], funct3[2:0]}.
    if (FUNCT_W != 10) begin : g_bad_funct_w
        $error("alu_ctrl_seq: FUNCT_W must be 10");
    end

    // ------------------------------------------------------------------
    // ALU control codes
    // ------------------------------------------------------------------
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_XOR  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_ADD  = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_SRAI = 3'b110;

    // ALUOp modes
    localparam logic [1:0] OP_RTYPE  = 2'b00;
    localparam logic [1:0] OP_IMM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;
    localparam logic [1:0] OP_PASS   = 2'b11;

    // A single-cycle MUL behaves exactly like any other op and never
    // enters MUL_WAIT.
    localparam bit               MUL_MULTI = (MUL_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MUL_LAT - 1);

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------
    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic [2:0]         ctrl_d;
    logic               valid_d;
    logic               illegal_d;

    logic [2:0]         dec_code;
    logic               dec_legal;
    logic               dec_mul;
    logic [2:0]         funct3;

    logic               accept;
    logic               mul_last;

    assign funct3 = funct_i[2:0];

    // The stall request is simply "a multi-cycle MUL is occupying EX".
    assign busy_o = (state_q == MUL_WAIT);

    // An instruction is taken only when EX is free and no flush is pending.
    assign accept = valid_i && !busy_o && !flush_i;

    // Last counting cycle of a multi-cycle MUL; the result is final next cycle.
    assign mul_last = (state_q == MUL_WAIT) && (cnt_q == CNT_LAST);

    // ------------------------------------------------------------------
    // Instruction decode: funct/ALUOp -> ALU control code + legality
    // ------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        dec_code  = ALU_ADD;
        dec_legal = 1'b0;
        case (ALUOp_i)
            OP_RTYPE: begin
                // Full 10-bit match; anything not listed is undecodable.
                case (funct_i)
                    10'b0000000_111: begin dec_code = ALU_AND; dec_legal = 1'b1; end
                    10'b0000000_100: begin dec_code = ALU_XOR; dec_legal = 1'b1; end
                    10'b0000000_001: begin dec_code = ALU_SLL; dec_legal = 1'b1; end
                    10'b0000000_000: begin dec_code = ALU_ADD; dec_legal = 1'b1; end
                    10'b0100000_000: begin dec_code = ALU_SUB; dec_legal = 1'b1; end
                    10'b0000001_000: begin dec_code = ALU_MUL; dec_legal = 1'b1; end
                    default:         begin dec_code = ALU_ADD; dec_legal = 1'b0; end
                endcase
            end
            OP_IMM: begin
                // Immediate / load / store: only funct3 is meaningful.
                case (funct3)
                    3'b000,
                    3'b010:  begin dec_code = ALU_ADD;  dec_legal = 1'b1; end
                    3'b101:  begin dec_code = ALU_SRAI; dec_legal = 1'b1; end
                    default: begin dec_code = ALU_ADD;  dec_legal = 1'b0; end
                endcase
            end
            OP_BRANCH: begin
                dec_code  = ALU_SUB;
                dec_legal = 1'b1;
            end
            OP_PASS: begin
                dec_code  = ALU_ADD;
                dec_legal = 1'b1;
            end
            default: begin
                dec_code  = ALU_ADD;
                dec_legal = 1'b0;
            end
        endcase
    end

    assign dec_mul = dec_legal && (dec_code == ALU_MUL);

    // ------------------------------------------------------------------
    // State register: FSM, MUL counter and registered outputs
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking <= so every register samples the
    // pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ALUCtrl_o <= ALU_AND;
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ALUCtrl_o <= ctrl_d;
            valid_o   <= valid_d;
            illegal_o <= illegal_d;
        end
    end

    // Next-state logic: enter MUL_WAIT on a multi-cycle MUL, count, return.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && dec_mul && MUL_MULTI) begin
                        state_d = MUL_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
                MUL_WAIT: begin
                    if (mul_last) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output logic: next values of ALUCtrl_o / valid_o / illegal_o.
    always_comb begin
        ctrl_d    = ALUCtrl_o;     // the control code holds unless replaced
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        if (!flush_i) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (!dec_legal) begin
                            // Report the bad encoding but keep the old code.
                            valid_d   = 1'b1;
                            illegal_d = 1'b1;
                        end else if (dec_mul && MUL_MULTI) begin
                            // Code is driven now; the result is not final yet.
                            ctrl_d  = ALU_MUL;
                            valid_d = 1'b0;
                        end else begin
                            ctrl_d  = dec_code;
                            valid_d = 1'b1;
                        end
                    end
                end
                MUL_WAIT: begin
                    valid_d = mul_last;
                end
                default: begin
                    valid_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: self-checking bench for alu_ctrl_seq.
// Two instances share the same stimulus: one with MUL_LAT=4 and one with
// MUL_LAT=1. A behavioural reference model produces the expected outputs of
// each instance at every clock edge; they are queued and popped/compared on
// the following falling edge.

module tb_alu_ctrl_seq;

    // ------------------------------------------------------------------
    // Types
    // ------------------------------------------------------------------
    typedef struct {
        logic [2:0] ctrl;
        logic       valid;
        logic       illegal;
        int         remain;   // busy cycles still to come after this one
    } model_t;

    typedef struct {
        logic [2:0] ctrl;
        logic       valid;
        logic       busy;
        logic       illegal;
    } exp_t;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic       clk_i;
    logic       rst_i;
    logic       valid_i;
    logic [9:0] funct_i;
    logic [1:0] ALUOp_i;
    logic       flush_i;

    logic [2:0] ctrl4;
    logic       valid4;
    logic       busy4;
    logic       illegal4;

    logic [2:0] ctrl1;
    logic       valid1;
    logic       busy1;
    logic       illegal1;

    int n_checks = 0;
    int n_errors = 0;
    int step_no  = 0;

    model_t m4;
    model_t m1;
    exp_t   sb4[$];
    exp_t   sb1[$];

    logic   busy1_seen = 1'b0;

    // Encodings used by the directed and random stimulus
    localparam logic [9:0] F_AND = 10'b0000000_111;
    localparam logic [9:0] F_XOR = 10'b0000000_100;
    localparam logic [9:0] F_SLL = 10'b0000000_001;
    localparam logic [9:0] F_ADD = 10'b0000000_000;
    localparam logic [9:0] F_SUB = 10'b0100000_000;
    localparam logic [9:0] F_MUL = 10'b0000001_000;

    // ------------------------------------------------------------------
    // DUT instances
    // ------------------------------------------------------------------
    alu_ctrl_seq #(.MUL_LAT(4), .FUNCT_W(10), .CNT_W(4)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .funct_i   (funct_i),
        .ALUOp_i   (ALUOp_i),
        .flush_i   (flush_i),
        .ALUCtrl_o (ctrl4),
        .valid_o   (valid4),
        .busy_o    (busy4),
        .illegal_o (illegal4)
    );

    alu_ctrl_seq #(.MUL_LAT(1), .FUNCT_W(10), .CNT_W(4)) dut_lat1 (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .funct_i   (funct_i),
        .ALUOp_i   (ALUOp_i),
        .flush_i   (flush_i),
        .ALUCtrl_o (ctrl1),
        .valid_o   (valid1),
        .busy_o    (busy1),
        .illegal_o (illegal1)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // The single-cycle instance must never request a stall.
    always @(posedge clk_i) begin
        if (busy1 === 1'b1) busy1_seen <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    // Returns {legal, code} for an ALUOp/funct pair.
    function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [9:0] f);
        logic [11:0] key;
        key = {op, f};
        casez (key)
            12'b00_0000000_111: return {1'b1, 3'b000};
            12'b00_0000000_100: return {1'b1, 3'b001};
            12'b00_0000000_001: return {1'b1, 3'b010};
            12'b00_0000000_000: return {1'b1, 3'b011};
            12'b00_0100000_000: return {1'b1, 3'b100};
            12'b00_0000001_000: return {1'b1, 3'b101};
            12'b01_???????_000: return {1'b1, 3'b011};
            12'b01_???????_010: return {1'b1, 3'b011};
            12'b01_???????_101: return {1'b1, 3'b110};
            12'b10_??????????:  return {1'b1, 3'b100};
            12'b11_??????????:  return {1'b1, 3'b011};
            default:            return {1'b0, 3'b000};
        endcase
    endfunction

    // Outputs after one clock edge, given the state before it and the inputs.
    function automatic model_t model_next(input model_t m, input int lat,
                                          input logic r, input logic v,
                                          input logic [1:0] op, input logic [9:0] f,
                                          input logic fl);
        model_t     n;
        logic [3:0] d;
        n         = m;
        n.valid   = 1'b0;
        n.illegal = 1'b0;
        if (!r) begin
            n.ctrl   = 3'b000;
            n.remain = 0;
        end else if (fl) begin
            n.remain = 0;
        end else if (m.remain > 0) begin
            n.remain = m.remain - 1;
            n.valid  = (n.remain == 0);
        end else if (v) begin
            d = ref_decode(op, f);
            if (!d[3]) begin
                n.valid   = 1'b1;
                n.illegal = 1'b1;
            end else if (d[2:0] == 3'b101 && lat > 1) begin
                n.ctrl   = 3'b101;
                n.remain = lat - 1;
            end else begin
                n.ctrl  = d[2:0];
                n.valid = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic exp_t to_exp(input model_t m);
        exp_t e;
        e.ctrl    = m.ctrl;
        e.valid   = m.valid;
        e.busy    = (m.remain > 0);
        e.illegal = m.illegal;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare(input string name, input exp_t e,
                           input logic [2:0] c, input logic v,
                           input logic b, input logic il);
        check($sformatf("%s ctrl step%0d", name, step_no),    {29'd0, c}, {29'd0, e.ctrl});
        check($sformatf("%s valid step%0d", name, step_no),   {31'd0, v}, {31'd0, e.valid});
        check($sformatf("%s busy step%0d", name, step_no),    {31'd0, b}, {31'd0, e.busy});
        check($sformatf("%s illegal step%0d", name, step_no), {31'd0, il}, {31'd0, e.illegal});
    endtask

    // One clock cycle: drive, predict at the edge, compare on the falling edge.
    task automatic step(input logic r, input logic v, input logic [1:0] op,
                        input logic [9:0] f, input logic fl);
        exp_t e;
        rst_i   = r;
        valid_i = v;
        ALUOp_i = op;
        funct_i = f;
        flush_i = fl;
        @(posedge clk_i);
        m4 = model_next(m4, 4, r, v, op, f, fl);
        m1 = model_next(m1, 1, r, v, op, f, fl);
        sb4.push_back(to_exp(m4));
        sb1.push_back(to_exp(m1));
        @(negedge clk_i);
        if (sb4.size() == 0 || sb1.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard underflow step%0d", step_no);
        end else begin
            e = sb4.pop_front();
            compare("lat4", e, ctrl4, valid4, busy4, illegal4);
            e = sb1.pop_front();
            compare("lat1", e, ctrl1, valid1, busy1, illegal1);
        end
        step_no++;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 2'b00, 10'd0, 1'b0);
    endtask

    task automatic op(input logic [1:0] aop, input logic [9:0] f);
        step(1'b1, 1'b1, aop, f, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [9:0] pool [8];
        logic       r;
        logic       v;
        logic       fl;
        logic [1:0] aop;
        logic [9:0] f;

        pool = '{F_AND, F_XOR, F_SLL, F_ADD, F_SUB, F_MUL,
                 10'b1111111_101, 10'b0000000_011};

        m4 = '{3'd0, 1'b0, 1'b0, 0};
        m1 = '{3'd0, 1'b0, 1'b0, 0};
        rst_i   = 1'b0;
        valid_i = 1'b0;
        funct_i = '0;
        ALUOp_i = 2'b00;
        flush_i = 1'b0;

        // Reset held two cycles with a MUL presented
        step(1'b0, 1'b1, 2'b00, F_MUL, 1'b0);
        step(1'b0, 1'b1, 2'b00, F_MUL, 1'b0);

        // R-type sweep, one op per cycle
        op(2'b00, F_AND);
        op(2'b00, F_XOR);
        op(2'b00, F_SLL);
        op(2'b00, F_ADD);
        op(2'b00, F_SUB);

        // MUL at T; ADD presented from T+2 is ignored until T+4
        op(2'b00, F_MUL);
        idle();
        op(2'b00, F_ADD);
        op(2'b00, F_ADD);
        op(2'b00, F_ADD);
        idle();

        // Immediate and branch, then an illegal immediate funct3
        op(2'b01, 10'b0000000_000);
        op(2'b01, 10'b1010101_010);
        op(2'b01, 10'b0100000_101);
        op(2'b10, 10'b1111111_111);
        op(2'b01, 10'b0000000_111);
        op(2'b11, 10'b0110011_110);
        op(2'b00, 10'b0100000_111);   // illegal R-type
        idle();

        // Flush mid-MUL with a valid ADD dropped, then SUB
        op(2'b00, F_MUL);
        idle();
        step(1'b1, 1'b1, 2'b00, F_ADD, 1'b1);
        op(2'b00, F_SUB);
        idle();

        // Reset mid-MUL
        op(2'b00, F_MUL);
        idle();
        step(1'b0, 1'b1, 2'b00, F_ADD, 1'b0);
        idle();

        // Back-to-back MULs
        op(2'b00, F_MUL);
        idle();
        idle();
        idle();
        op(2'b00, F_MUL);
        idle();
        idle();
        idle();
        idle();

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            v   = ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0;
            fl  = ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0;
            aop = ($urandom_range(0, 99) < 55) ? 2'b00 : 2'($urandom_range(0, 3));
            f   = ($urandom_range(0, 99) < 80) ? pool[$urandom_range(0, 7)]
                                               : 10'($urandom_range(0, 1023));
            step(r, v, aop, f, fl);
        end
        idle();
        idle();
        idle();
        idle();

        check("lat1 busy never asserted", {31'd0, busy1_seen}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Registered, multi-cycle-aware ALU control for the ID/EX boundary of the pipelined CPU.
- Decodes funct/ALUOp into the 3-bit ALU control code.
- Adds branch and pass-through ALUOp modes.
- Sequences a parametrised-latency MUL and stalls upstream while it runs.
- Flags unsupported encodings.

Parameters:
MUL_LAT, 4, cycles a MUL occupies EX; legal range 1..15; 1 means single-cycle like every other op
FUNCT_W, 10, width of funct_i ({funct7, funct3})
CNT_W, 4, width of the internal MUL counter; must hold MUL_LAT

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous reset, active-low
valid_i  input  1  instruction present on funct_i/ALUOp_i this cycle
funct_i  input  FUNCT_W  {funct7[6:0], funct3[2:0]}
ALUOp_i  input  2  00 R-type, 01 immediate/load/store, 10 branch, 11 pass-add
flush_i  input  1  pipeline flush; kills the current and in-flight op
ALUCtrl_o  output  3  registered ALU control code
valid_o  output  1  ALUCtrl_o is final for the op in EX this cycle
busy_o  output  1  stall request to IF/ID; high while a MUL is in progress
illegal_o  output  1  one-cycle pulse with valid_o for an undecodable encoding

Behaviour:
- Codes: AND 000, XOR 001, SLL 010, ADD 011, SUB 100, MUL 101, SRAI 110.
- Decode, ALUOp 00, full 10-bit match:
  - 0000000_111 AND; 0000000_100 XOR; 0000000_001 SLL
  - 0000000_000 ADD; 0100000_000 SUB; 0000001_000 MUL
- Decode, ALUOp 01, funct3 only: 000 ADD; 010 ADD; 101 SRAI.
- Decode, ALUOp 10: always SUB, funct ignored.
- Decode, ALUOp 11: always ADD, funct ignored.
- Any other encoding is illegal:
  - ALUCtrl_o holds its previous value.
  - valid_o=1 and illegal_o=1 for that one cycle.
- Accept: the instruction is accepted at edge T when rst_i=1, valid_i=1, busy_o=0, flush_i=0. Inputs while busy_o=1 are ignored.
- Reset: when rst_i=0 at an edge:
  - ALUCtrl_o=000, valid_o=0, busy_o=0, illegal_o=0.
  - FSM=IDLE, counter=0.
  - Reset overrides all other inputs, including mid-MUL.
- FSM states: IDLE, MUL_WAIT.
- IDLE, accepted non-MUL op, or MUL with MUL_LAT=1:
  - At T+1: ALUCtrl_o=code, valid_o=1.
  - Stay in IDLE.
- IDLE, accepted MUL with MUL_LAT>1:
  - At T+1: ALUCtrl_o=101, valid_o=0, busy_o=1, counter=1, go to MUL_WAIT.
- MUL_WAIT:
  - Counter increments each cycle.
  - When the counter reaches MUL_LAT-1, the next cycle (T+MUL_LAT) has valid_o=1, busy_o=0, and the FSM returns to IDLE.
  - busy_o is high exactly for cycles T+1 .. T+MUL_LAT-1.
  - ALUCtrl_o stays 101 throughout.
- Back-to-back: a new instruction presented at T+MUL_LAT is accepted and produces its result at T+MUL_LAT+1.
- No accepted instruction: valid_o=0, illegal_o=0, ALUCtrl_o holds.
- flush_i=1 at an edge, from any state:
  - Next cycle valid_o=0, busy_o=0, illegal_o=0, FSM=IDLE, counter=0.
  - ALUCtrl_o holds.
  - A valid_i in the same cycle is dropped.
- Counter wrap is impossible: MUL_LAT ≤ 2^CNT_W-1 is enforced by an elaboration-time check.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles with valid_i=1, funct=0000001_000 -> ALUCtrl_o=000, valid_o=0, busy_o=0 throughout.
- R-type sweep, ALUOp=00, one op per cycle: AND, XOR, SLL, ADD, SUB -> ALUCtrl_o sequence 000,001,010,011,100, each one cycle after input, valid_o=1 each cycle.
- MUL with MUL_LAT=4, accepted at T:
  - busy_o=1 at T+1..T+3, valid_o=0 there.
  - ALUCtrl_o=101, valid_o=1, busy_o=0 at T+4.
  - An ADD presented at T+2 is ignored; the same ADD held to T+4 gives 011 at T+5.
- Immediate and branch, ALUOp 01 with funct3 000/010/101, then ALUOp 10 -> 011, 011, 110, 100. Then ALUOp 01 with funct3 111 -> illegal_o=1, valid_o=1, ALUCtrl_o=100 (held).
- Flush mid-MUL: MUL at T, flush_i=1 at T+2 -> at T+3 busy_o=0, valid_o=0. Then a SUB at T+3 -> 100 at T+4.
- Reset mid-MUL: rst_i=0 at T+2 -> at T+3 all outputs at reset values and FSM=IDLE. Then repeat with MUL_LAT=1 -> MUL gives 101 with valid_o=1 at T+1 and busy_o never asserts.
